// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES controller types and constants
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_ctrl_state_t;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES128_ROUNDS = 10;

endpackage

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - sequencing controller for a registered AES-128 round datapath
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data      plaintext block handshake
//   key_idx/key_in/key_valid       round-key fetch from the key store
//   dp_data/dp_round_key/
//   dp_last_round/dp_result        round datapath drive and result
//   out_valid/out_ready/out_data   ciphertext handshake
//   busy, round_cnt                status
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int ROUND_LAT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic [127:0] dp_data,
  output logic [127:0] dp_round_key,
  output logic         dp_last_round,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_WAIT = 4'(ROUND_LAT);

  aes_ctrl_state_t        state_q;
  logic [AES_BLOCK_W-1:0] blk_q;
  logic [3:0]             round_q;
  logic [3:0]             wait_q;
  logic                   in_round;

  assign in_round = (state_q == ROUND);

  // rst gates in_ready so no block is claimed during the reset cycle
  assign in_ready = (state_q == IDLE) && key_valid && !rst;

  // round_q is 0 in IDLE and DONE, so IDLE naturally fetches the whitening key
  assign key_idx       = round_q;
  assign dp_data       = in_round ? blk_q  : '0;
  assign dp_round_key  = in_round ? key_in : '0;
  assign dp_last_round = in_round && (round_q == LAST_RND);

  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? blk_q : '0;
  assign busy      = (state_q != IDLE);
  assign round_cnt = round_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      round_q <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            blk_q   <= in_data ^ key_in;
            round_q <= 4'd1;
            wait_q  <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          // key_valid only gates the start of a window; once the datapath
          // inputs are launched the window runs to completion
          if ((wait_q == '0) && !key_valid) begin
            wait_q <= wait_q;
          end else if (wait_q == LAST_WAIT) begin
            blk_q  <= dp_result;
            wait_q <= '0;
            if (round_q == LAST_RND) begin
              round_q <= '0;
              state_q <= DONE;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
